// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: ALU op codes, decode-stage aluop/funct encodings and the ALU control decode shared by the ID/EX stage.
package id_ex_stage_pkg;

    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;
    localparam logic [2:0] ALU_RESET = ALU_ADD;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef struct packed {
        logic       illegal;
        logic [2:0] op;
    } alu_dec_t;

    // Unknown R-type functs fall back to ADD but are flagged illegal.
    function automatic alu_dec_t decode_alu(input logic [1:0] aluop, input logic [5:0] funct);
        alu_dec_t   d;
        logic [2:0] rop;
        logic       legal;
        rop   = funct == FUNCT_ADD ? ALU_ADD :
                funct == FUNCT_SUB ? ALU_SUB :
                funct == FUNCT_AND ? ALU_AND :
                funct == FUNCT_OR  ? ALU_OR  :
                funct == FUNCT_SLT ? ALU_SLT : ALU_ADD;
        legal = funct == FUNCT_ADD || funct == FUNCT_SUB || funct == FUNCT_AND ||
                funct == FUNCT_OR  || funct == FUNCT_SLT;
        d.op  = aluop == ALUOP_ADD ? ALU_ADD :
                aluop == ALUOP_SUB ? ALU_SUB :
                aluop == ALUOP_OR  ? ALU_OR  : rop;
        d.illegal = aluop == ALUOP_RTYPE && !legal;
        return d;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// fwd_sel: picks the newest value of one register operand from EX/MEM, MEM/WB or the stored copy.
module fwd_sel #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic [REGW-1:0]  idx,
    input  logic [WIDTH-1:0] val,
    input  logic             exm_regwrite,
    input  logic [REGW-1:0]  exm_dst,
    input  logic [WIDTH-1:0] exm_result,
    input  logic             wb_regwrite,
    input  logic [REGW-1:0]  wb_dst,
    input  logic [WIDTH-1:0] wb_result,
    output logic [WIDTH-1:0] fwd
);
    logic nz;
    assign nz  = |idx;
    assign fwd = (exm_regwrite && nz && exm_dst == idx) ? exm_result :
                 (wb_regwrite  && nz && wb_dst  == idx) ? wb_result  : val;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU control decode, operand forwarding, stall and flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rd1,
    input  logic [WIDTH-1:0] id_rd2,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [REGW-1:0]  id_rs,
    input  logic [REGW-1:0]  id_rt,
    input  logic [REGW-1:0]  id_rd,
    input  logic [1:0]       id_aluop,
    input  logic [5:0]       id_funct,
    input  logic             id_alusrc,
    input  logic             id_regdst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             exm_regwrite,
    input  logic [REGW-1:0]  exm_dst,
    input  logic [WIDTH-1:0] exm_result,
    input  logic             wb_regwrite,
    input  logic [REGW-1:0]  wb_dst,
    input  logic [WIDTH-1:0] wb_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [REGW-1:0]  ex_dst,
    output logic             ex_valid,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_illegal
);
    logic             valid, alusrc, regwrite, memread, memwrite, memtoreg, illegal;
    logic [REGW-1:0]  rs, rt, dst;
    logic [WIDTH-1:0] rd1, rd2, imm, fwd_a, fwd_b;
    logic [2:0]       op;
    alu_dec_t         dec;

    assign dec = decode_alu(id_aluop, id_funct);

    fwd_sel #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_a (
        .idx(rs), .val(rd1),
        .exm_regwrite(exm_regwrite), .exm_dst(exm_dst), .exm_result(exm_result),
        .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_result(wb_result),
        .fwd(fwd_a)
    );

    fwd_sel #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_b (
        .idx(rt), .val(rd2),
        .exm_regwrite(exm_regwrite), .exm_dst(exm_dst), .exm_result(exm_result),
        .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_result(wb_result),
        .fwd(fwd_b)
    );

    // A stalled instruction refreshes its operands so writebacks retiring during the stall stick.
    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && !id_valid)) begin
            valid    <= 1'b0;
            alusrc   <= 1'b0;
            regwrite <= 1'b0;
            memread  <= 1'b0;
            memwrite <= 1'b0;
            memtoreg <= 1'b0;
            illegal  <= 1'b0;
            rs       <= '0;
            rt       <= '0;
            dst      <= '0;
            rd1      <= '0;
            rd2      <= '0;
            imm      <= '0;
            op       <= ALU_RESET;
        end else if (stall) begin
            rd1 <= fwd_a;
            rd2 <= fwd_b;
        end else begin
            valid    <= 1'b1;
            alusrc   <= id_alusrc;
            regwrite <= id_regwrite;
            memread  <= id_memread;
            memwrite <= id_memwrite;
            memtoreg <= id_memtoreg;
            illegal  <= dec.illegal;
            rs       <= id_rs;
            rt       <= id_rt;
            dst      <= id_regdst ? id_rd : id_rt;
            rd1      <= id_rd1;
            rd2      <= id_rd2;
            imm      <= id_imm;
            op       <= dec.op;
        end
    end

    assign alu_a         = fwd_a;
    assign alu_b         = alusrc ? imm : fwd_b;
    assign alu_op        = op;
    assign ex_store_data = fwd_b;
    assign ex_dst        = dst;
    assign ex_valid      = valid;
    assign ex_regwrite   = regwrite & valid;
    assign ex_memread    = memread & valid;
    assign ex_memwrite   = memwrite & valid;
    assign ex_memtoreg   = memtoreg;
    assign ex_illegal    = illegal & valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard-driven bench for the ID/EX stage covering decode, forwarding, stall and flush.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1, stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [31:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic [1:0]  id_aluop = '0;
    logic [5:0]  id_funct = '0;
    logic        id_alusrc = 1'b0, id_regdst = 1'b0, id_regwrite = 1'b0;
    logic        id_memread = 1'b0, id_memwrite = 1'b0, id_memtoreg = 1'b0;
    logic        exm_regwrite = 1'b0, wb_regwrite = 1'b0;
    logic [4:0]  exm_dst = '0, wb_dst = '0;
    logic [31:0] exm_result = '0, wb_result = '0;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_op;
    logic [4:0]  ex_dst;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] st;
        logic [4:0]  dst;
        logic        v, rw, mr, mw, mtr, ill;
    } obs_t;

    obs_t obs, e;
    obs_t sb[$];
    int   errors = 0, checks = 0;

    assign obs = {alu_a, alu_b, alu_op, ex_store_data, ex_dst,
                  ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal};

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_aluop(id_aluop), .id_funct(id_funct),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exm_regwrite(exm_regwrite), .exm_dst(exm_dst), .exm_result(exm_result),
        .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_dst(ex_dst), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    function automatic obs_t bub();
        obs_t r = '0;
        r.op = 3'b010;
        return r;
    endfunction

    function automatic obs_t ins(input logic [31:0] a, b, input logic [2:0] op, input logic [31:0] st,
                                 input logic [4:0] dst, input logic rw, mr, mw, mtr, ill);
        obs_t r;
        r.a = a; r.b = b; r.op = op; r.st = st; r.dst = dst;
        r.v = 1'b1; r.rw = rw; r.mr = mr; r.mw = mw; r.mtr = mtr; r.ill = ill;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs, rt, rd, input logic [31:0] d1, d2, im,
                         input logic [1:0] aop, input logic [5:0] fn,
                         input logic src, rdst, rw, mr, mw, mtr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rd1 = d1; id_rd2 = d2; id_imm = im; id_aluop = aop; id_funct = fn;
        id_alusrc = src; id_regdst = rdst; id_regwrite = rw;
        id_memread = mr; id_memwrite = mw; id_memtoreg = mtr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        string nm [3] = '{"reset_hold1", "reset_hold2", "reset_release"};
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin reset = 1'b0; stall = 1'b0; id_valid = 1'b0; end
            sb.push_back(bub());
            step();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL %s got=%h exp=%h", nm[i], obs, e); end
        end
    endtask

    task automatic test_rtype();
        drive(1, 5'd1, 5'd2, 5'd7, 32'd5, 32'd3, 32'd0, 2'b10, 6'h22, 0, 1, 1, 0, 0, 0);
        sb.push_back(ins(32'd5, 32'd3, 3'b110, 32'd3, 5'd7, 1, 0, 0, 0, 0));
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rtype_sub got=%h exp=%h", obs, e); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  aop [8] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [5:0]  fn  [8] = '{6'h22, 6'h00, 6'h00, 6'h00, 6'h20, 6'h24, 6'h25, 6'h2A};
        logic [2:0]  eop [8] = '{3'b110, 3'b010, 3'b110, 3'b001, 3'b010, 3'b000, 3'b001, 3'b111};
        logic [31:0] d1, d2, im;
        logic [4:0]  rd, rt;
        logic        src, rdst, rw, ld;
        for (int i = 0; i < 8; i++) begin
            d1 = $urandom; d2 = $urandom; im = $urandom;
            rd = 5'(20 + i); rt = 5'(i + 1);
            src = (i == 1); ld = (i == 1); rw = (i != 3); rdst = (aop[i] == 2'b10);
            drive(1, 5'(10 + i), rt, rd, d1, d2, im, aop[i], fn[i], src, rdst, rw, ld, 0, ld);
            sb.push_back(ins(d1, src ? im : d2, eop[i], d2, rdst ? rd : rt, rw, ld, 0, ld, 0));
            step();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL b2b_%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_forward();
        drive(1, 5'd4, 5'd4, 5'd5, 32'h11, 32'h22, 32'd0, 2'b00, 6'h00, 0, 1, 1, 0, 0, 0);
        sb.push_back(ins(32'h11, 32'h22, 3'b010, 32'h22, 5'd5, 1, 0, 0, 0, 0));
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL fwd_loaded got=%h exp=%h", obs, e); end
        exm_regwrite = 1; exm_dst = 5'd4; exm_result = 32'hAA;
        wb_regwrite = 1; wb_dst = 5'd4; wb_result = 32'hBB;
        sb.push_back(ins(32'hAA, 32'hAA, 3'b010, 32'hAA, 5'd5, 1, 0, 0, 0, 0));
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL fwd_exm_wins got=%h exp=%h", obs, e); end
        exm_regwrite = 0;
        sb.push_back(ins(32'hBB, 32'hBB, 3'b010, 32'hBB, 5'd5, 1, 0, 0, 0, 0));
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL fwd_wb got=%h exp=%h", obs, e); end
        exm_regwrite = 1; exm_dst = 5'd0; wb_dst = 5'd0;
        drive(1, 5'd0, 5'd0, 5'd5, 32'h33, 32'h44, 32'd0, 2'b00, 6'h00, 0, 1, 1, 0, 0, 0);
        sb.push_back(ins(32'h33, 32'h44, 3'b010, 32'h44, 5'd5, 1, 0, 0, 0, 0));
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL fwd_r0 got=%h exp=%h", obs, e); end
        exm_regwrite = 0; wb_regwrite = 0;
    endtask

    task automatic test_stall();
        drive(1, 5'd3, 5'd9, 5'd6, 32'h10, 32'h20, 32'd0, 2'b10, 6'h20, 0, 1, 1, 0, 0, 0);
        sb.push_back(ins(32'h10, 32'h20, 3'b010, 32'h20, 5'd6, 1, 0, 0, 0, 0));
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_loaded got=%h exp=%h", obs, e); end
        stall = 1; wb_regwrite = 1; wb_dst = 5'd9; wb_result = 32'h1234;
        drive(1, 5'd1, 5'd2, 5'd3, 32'hDEAD, 32'hBEEF, 32'd0, 2'b01, 6'h00, 0, 1, 1, 0, 0, 0);
        sb.push_back(ins(32'h10, 32'h1234, 3'b010, 32'h1234, 5'd6, 1, 0, 0, 0, 0));
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_cycle1 got=%h exp=%h", obs, e); end
        step();
        wb_regwrite = 0;
        sb.push_back(ins(32'h10, 32'h1234, 3'b010, 32'h1234, 5'd6, 1, 0, 0, 0, 0));
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_cycle2 got=%h exp=%h", obs, e); end
        sb.push_back(ins(32'h10, 32'h1234, 3'b010, 32'h1234, 5'd6, 1, 0, 0, 0, 0));
        step();
        stall = 0;
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_release got=%h exp=%h", obs, e); end
        sb.push_back(ins(32'hDEAD, 32'hBEEF, 3'b110, 32'hBEEF, 5'd3, 1, 0, 0, 0, 0));
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_next_load got=%h exp=%h", obs, e); end
        stall = 1; reset = 1;
        sb.push_back(bub());
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_mid_stall got=%h exp=%h", obs, e); end
        stall = 0; reset = 0;
    endtask

    task automatic test_stall_flush();
        drive(1, 5'd2, 5'd5, 5'd0, 32'h1000, 32'hCAFE, 32'd8, 2'b00, 6'h00, 1, 0, 0, 0, 1, 0);
        sb.push_back(ins(32'h1000, 32'd8, 3'b010, 32'hCAFE, 5'd5, 0, 0, 1, 0, 0));
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL sw_loaded got=%h exp=%h", obs, e); end
        stall = 1; flush = 1;
        sb.push_back(bub());
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_flush got=%h exp=%h", obs, e); end
        stall = 0; flush = 0;
        drive(0, 5'd2, 5'd5, 5'd6, 32'h1, 32'h2, 32'd8, 2'b10, 6'h27, 1, 1, 1, 1, 1, 1);
        sb.push_back(bub());
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL invalid_bubble got=%h exp=%h", obs, e); end
    endtask

    task automatic test_illegal();
        drive(1, 5'd1, 5'd2, 5'd4, 32'd7, 32'd8, 32'd0, 2'b10, 6'h27, 0, 1, 1, 0, 0, 0);
        sb.push_back(ins(32'd7, 32'd8, 3'b010, 32'd8, 5'd4, 1, 0, 0, 0, 1));
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL illegal_set got=%h exp=%h", obs, e); end
        flush = 1;
        sb.push_back(bub());
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL illegal_flushed got=%h exp=%h", obs, e); end
        flush = 0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_back_to_back();
        test_forward();
        test_stall();
        test_stall_flush();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage directly upstream of the 32-bit ALU. Registers decoded instruction fields and control from the decode stage. Decodes the 3-bit ALU op code. Forwards EX/MEM and MEM/WB results onto stale register operands and drives the ALU a/b/op inputs for one instruction per cycle. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
WIDTH, 32, datapath width of operands/results
REGW, 5, register-index width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold stage contents this cycle
flush  in  1  load bubble this cycle
id_valid  in  1  decode slot holds a real instruction
id_rd1, id_rd2  in  WIDTH  register-file read data (rs, rt)
id_imm  in  WIDTH  sign-extended immediate
id_rs, id_rt, id_rd  in  REGW  register indices
id_aluop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or
id_funct  in  6  R-type function field
id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1  decode control
exm_regwrite  in  1  EX/MEM will write a register
exm_dst  in  REGW  EX/MEM destination
exm_result  in  WIDTH  EX/MEM ALU result
wb_regwrite  in  1  MEM/WB will write a register
wb_dst  in  REGW  MEM/WB destination
wb_result  in  WIDTH  MEM/WB writeback value
alu_a, alu_b  out  WIDTH  ALU operands
alu_op  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
ex_store_data  out  WIDTH  forwarded rt value for stores
ex_dst  out  REGW  destination index
ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal  out  1  status/control to EX/MEM

Behaviour:
- One clock (clk). Reset is synchronous and active-high. Priority each rising edge: reset > flush > stall > load.
- Reset or flush: valid=0, all control 0, ex_illegal=0, stored data/indices 0, stored alu_op=010. The ALU output ports then read 0 apart from alu_op=010. Forwarding still applies: with exm_dst and wb_dst equal to 0, nothing forwards.
- Load (no stall): capture all id_* fields in one cycle; latency ID->EX is 1 cycle.
- At capture: store dst = id_regdst ? id_rd : id_rt.
- At capture: decode alu_op:
  - aluop 00 -> 010; 01 -> 110; 11 -> 001.
  - aluop 10 by funct: 0x20 -> 010; 0x22 -> 110; 0x24 -> 000; 0x25 -> 001; 0x2A -> 111.
  - aluop 10 with any other funct -> alu_op 010 and illegal=1.
- id_valid=0 at load captures a bubble, identical to flush.
- Forwarding, combinational from the stored rs/rt and stored operands; applied per operand:
  - fwd = EX/MEM value if exm_regwrite and exm_dst==index and index!=0;
  - else MEM/WB value if wb_regwrite and wb_dst==index and index!=0;
  - else the stored value.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- alu_a = fwd_a. alu_b = alusrc ? imm : fwd_b. ex_store_data = fwd_b regardless of alusrc.
- Stall: indices, control, imm and alu_op hold. The stored rd1/rd2 are overwritten with fwd_a/fwd_b each stalled cycle, so a writeback that retires during the stall is not lost.
- Output gating: ex_regwrite, ex_memread, ex_memwrite and ex_illegal are each ANDed with the stored valid.
- Simultaneous stall+flush: flush wins and a bubble is loaded.
- Reset asserted mid-stall: bubble on the next edge; no stall state survives.

Decomposition:
- Shared package:
  - ALU op constants (AND/OR/ADD/SUB/SLT);
  - aluop encodings;
  - funct constants (0x20/0x22/0x24/0x25/0x2A);
  - the reset/bubble alu_op default.
- Sub-module fwd_sel: index, stored value and both forwarding sources in, forwarded value out. Instantiated twice (rs, rt).

Test Plan:
1. Reset held 2 cycles, then released with stall=0 and id_valid=0 -> ex_valid=0, all control 0, alu_op=010, alu_a=alu_b=0.
2. R-type load: rd1=5, rd2=3, aluop=10, funct=0x22, rd=7, regdst=1, regwrite=1 -> next cycle: alu_a=5, alu_b=3, alu_op=110, ex_dst=7, ex_regwrite=1.
3. Stored rs=4, rt=4; exm_dst=4 (exm_result=0xAA) and wb_dst=4 (wb_result=0xBB), both regwrite=1 -> alu_a=0xAA, ex_store_data=0xAA. Repeat with exm_dst=0 and rs=rt=0 -> stored values, no forwarding.
4. Stall for 2 cycles while wb writes rt=9 with 0x1234 in cycle 1 only -> alu_b=0x1234 in cycle 2 and after release.
5. stall=1 and flush=1 on the same edge with a valid sw instruction stored -> next cycle ex_valid=0, ex_memwrite=0.
6. aluop=10 with funct=0x27 -> ex_illegal=1, alu_op=010. Same instruction followed by a flush -> ex_illegal=0.
